jtag_chain_scan_ctrl: RTL and testbench
=======================================

// Module: jtag_chain_scan_ctrl
// PURPOSE
//   Sequences the two ECP5 JTAGG user chains (ER1/ER2) for their shift/data registers.
//   Tracks each scan through capture -> shift -> update and muxes the active chain's TDO.
//   Issues per-chain capture/shift/update enables and counts shifted bits.
//   Commits an update only when the scan length matches the chain's register length; else flags error.
//   Sits between the JTAGG primitive outputs and the user-chain register modules.
// PARAMETERS
//   LEN1   4   expected shift length (bits) of chain 1 register
//   LEN2   4   expected shift length (bits) of chain 2 register
//   CNT_W  8   width of bit_count; must satisfy 2**CNT_W-1 >= max(LEN1,LEN2)
// PORTS
//   JTCK         in   1      JTAG clock; all state changes on posedge JTCK
//   reset        in   1      synchronous, active-high reset
//   JCE1, JCE2   in   1      chain-enable strobes from JTAGG
//   JSHIFT       in   1      shift-DR indication
//   JUPDATE      in   1      update-DR indication
//   tdo1_i       in   1      serial out of chain 1 register
//   tdo2_i       in   1      serial out of chain 2 register
//   tdo_o        out  1      tdo of active chain (comb); 0 when IDLE
//   capture_en   out  2      one-hot capture enable [0]=chain1 [1]=chain2 (comb)
//   shift_en     out  2      one-hot shift enable (comb)
//   update_en    out  2      one-hot update enable (comb), at most 1 cycle per scan
//   active_chain out  2      one-hot latched chain of current scan; 00 in IDLE
//   bit_count    out  CNT_W  bits shifted in current scan, saturating
//   scan_ok      out  1      1-cycle pulse, cycle after a committed update
//   scan_err     out  1      1-cycle pulse, cycle after a rejected update or JCE conflict
//   err_count    out  8      rejected scans + conflicts, saturates at 255
// BEHAVIOUR
//   Reset (reset=1 at posedge): state=IDLE, active_chain=00, bit_count=0, err_count=0,
//     scan_ok=scan_err=0. While state=IDLE all enables=00 and tdo_o=0.
//   Enables are comb from registered state + current JCEx/JSHIFT/JUPDATE (0-cycle latency).
//   JCE_sel = JCEx of latched active chain.
//   States: IDLE, CAPTURE, SHIFT, UPD_WAIT.
//   IDLE: if (JCE1|JCE2) & !JSHIFT -> capture_en[sel]=1, latch sel, bit_count<=0, -> CAPTURE.
//     JCE1 & JCE2 both high -> chain1 wins, scan_err pulse, err_count++.
//     JCEx with JSHIFT=1 in IDLE (no capture seen) -> ignored, stay IDLE.
//     JUPDATE in IDLE -> ignored, no update, no error.
//   CAPTURE: JSHIFT & JCE_sel -> shift_en[sel]=1, bit_count++, -> SHIFT.
//     JCE_sel & !JSHIFT -> capture_en[sel]=1 again, stay.
//     JUPDATE -> zero-length scan: reject (see UPD_WAIT), -> IDLE.
//     JCE_sel low, no JUPDATE -> UPD_WAIT.
//   SHIFT: JSHIFT & JCE_sel -> shift_en[sel]=1, bit_count++ (saturate at 2**CNT_W-1).
//     JCE_sel low or JSHIFT low -> UPD_WAIT (pause/exit); no shift that cycle.
//   UPD_WAIT: JSHIFT & JCE_sel -> resume SHIFT (pause-DR re-entry), shift_en, count++.
//     JUPDATE: if bit_count == LEN_sel -> update_en[sel]=1, scan_ok next cycle;
//       else update_en=00, scan_err next cycle, err_count++ (sat 255). Either way -> IDLE.
//   tdo_o = tdo1_i if active_chain=01, tdo2_i if 10, else 0.
//   Other chain's enables always 0 during a scan; its JCE ignored until IDLE.
//   reset mid-scan: next cycle IDLE, no update_en, no scan_ok/err pulse.
//   scan_ok and scan_err never high together.
// TESTING
//   T1 chain2: JCE2 capture 1 cyc, 4 shift cyc, JUPDATE -> capture_en=10, shift_en=10 x4,
//      bit_count=4, update_en=10 one cyc, scan_ok pulse, err_count=0.
//   T2 chain1 with 3 shifts, JUPDATE -> update_en=00, scan_err pulse, err_count=1;
//      repeat 300 times -> err_count=255.
//   T3 chain2 shift 2, pause 3 cyc (JCE2=0), shift 2, JUPDATE -> bit_count=4, update_en=10.
//   T4 JCE1=JCE2=1 in IDLE -> active_chain=01, scan_err pulse, chain2 enables stay 0.
//   T5 reset=1 after 2 shifts -> state IDLE next cycle; later JUPDATE gives no update_en,
//      no pulses; bit_count=0.
//   T6 tdo mux: tdo1_i=1,tdo2_i=0 during chain1 scan -> tdo_o=1; in IDLE tdo_o=0.

Source files
------------

// File: rtl/jtag_chain_scan_ctrl.sv
// jtag_chain_scan_ctrl
//   Sequences the two ECP5 JTAGG user chains (ER1/ER2) through capture -> shift -> update.
//   It sits between the JTAGG primitive outputs and the user-chain register modules.
//   Scan length is counted, and an update is committed only when the length matches the
//   chain's register length; otherwise the scan is rejected and flagged.
//
// Ports
//   JTCK, reset           JTAG clock; synchronous active-high reset
//   JCE1, JCE2            chain-enable strobes from JTAGG
//   JSHIFT, JUPDATE       shift-DR / update-DR indications
//   tdo1_i, tdo2_i        serial outputs of the two chain registers
//   tdo_o                 TDO of the active chain, 0 when idle
//   capture_en/shift_en   one-hot per-chain enables ([0]=chain1, [1]=chain2), combinational
//   update_en             one-hot update enable, at most one cycle per scan
//   active_chain          one-hot chain latched for the current scan, 00 when idle
//   bit_count             bits shifted in the current scan, saturating
//   scan_ok / scan_err    one-cycle pulses after a committed / rejected scan (or JCE conflict)
//   err_count             rejected scans plus conflicts, saturating at 255
module jtag_chain_scan_ctrl #(
  parameter int unsigned LEN1  = 4,
  parameter int unsigned LEN2  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             JTCK,
  input  logic             reset,
  input  logic             JCE1,
  input  logic             JCE2,
  input  logic             JSHIFT,
  input  logic             JUPDATE,
  input  logic             tdo1_i,
  input  logic             tdo2_i,
  output logic             tdo_o,
  output logic [1:0]       capture_en,
  output logic [1:0]       shift_en,
  output logic [1:0]       update_en,
  output logic [1:0]       active_chain,
  output logic [CNT_W-1:0] bit_count,
  output logic             scan_ok,
  output logic             scan_err,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] Len1W = CNT_W'(LEN1);
  localparam logic [CNT_W-1:0] Len2W = CNT_W'(LEN2);

  typedef enum logic [1:0] {StIdle, StCapture, StShift, StUpdWait} state_e;

  state_e           state_q, state_d;
  logic [1:0]       active_q, active_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Per-cycle events decoded by the next-state logic.
  logic       ev_capture, ev_shift, ev_commit, ev_reject, ev_conflict;
  logic [1:0] start_sel;
  logic       jce_sel;
  logic [CNT_W-1:0] len_sel;

  // Chain 1 wins when both strobes arrive together in idle.
  assign start_sel = JCE1 ? 2'b01 : 2'b10;
  // Only the latched chain's strobe matters once a scan is under way.
  assign jce_sel   = (active_q[0] & JCE1) | (active_q[1] & JCE2);
  assign len_sel   = active_q[1] ? Len2W : Len1W;

  // State register and datapath flops.
  always_ff @(posedge JTCK) begin
    if (reset) begin
      state_q   <= StIdle;
      active_q  <= 2'b00;
      count_q   <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      count_q   <= count_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state and event decode. Events are suppressed while reset is asserted so that
  // a reset landing mid-scan can never fire an enable or an update.
  always_comb begin
    state_d     = state_q;
    ev_capture  = 1'b0;
    ev_shift    = 1'b0;
    ev_commit   = 1'b0;
    ev_reject   = 1'b0;
    ev_conflict = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          // JCE with JSHIFT already high means the capture was missed: ignore the scan.
          if ((JCE1 || JCE2) && !JSHIFT) begin
            ev_capture  = 1'b1;
            ev_conflict = JCE1 & JCE2;
            state_d     = StCapture;
          end
        end
        StCapture: begin
          if (JSHIFT && jce_sel) begin
            ev_shift = 1'b1;
            state_d  = StShift;
          end else if (jce_sel) begin
            ev_capture = 1'b1;
          end else if (JUPDATE) begin
            // Update with no shift at all is a zero-length scan.
            ev_reject = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StUpdWait;
          end
        end
        StShift: begin
          if (JSHIFT && jce_sel) begin
            ev_shift = 1'b1;
          end else begin
            state_d = StUpdWait;
          end
        end
        StUpdWait: begin
          if (JSHIFT && jce_sel) begin
            // Pause-DR re-entry.
            ev_shift = 1'b1;
            state_d  = StShift;
          end else if (JUPDATE) begin
            if (count_q == len_sel) begin
              ev_commit = 1'b1;
            end else begin
              ev_reject = 1'b1;
            end
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state.
  always_comb begin
    active_d  = active_q;
    count_d   = count_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (ev_capture && (state_q == StIdle)) begin
      active_d = start_sel;
      count_d  = '0;
    end
    if (ev_shift && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
    if (ev_commit) begin
      ok_d = 1'b1;
    end
    if (ev_reject || ev_conflict) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (state_d == StIdle) begin
      active_d = 2'b00;
    end
  end

  // Outputs.
  always_comb begin
    capture_en = 2'b00;
    shift_en   = 2'b00;
    update_en  = 2'b00;
    tdo_o      = 1'b0;
    if (ev_capture) begin
      capture_en = (state_q == StIdle) ? start_sel : active_q;
    end
    if (ev_shift) begin
      shift_en = active_q;
    end
    if (ev_commit) begin
      update_en = active_q;
    end
    if (active_q == 2'b01) begin
      tdo_o = tdo1_i;
    end else if (active_q == 2'b10) begin
      tdo_o = tdo2_i;
    end
  end

  assign active_chain = active_q;
  assign bit_count    = count_q;
  assign scan_ok      = ok_q;
  assign scan_err     = err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_jtag_chain_scan_ctrl.sv
// Bench for jtag_chain_scan_ctrl. Scenario tasks drive one cycle at a time and push the
// expected enables/pulses for that cycle; a negedge monitor pops and compares them.
// Scenario tasks also check counters, latched chain and TDO inline.
module tb_jtag_chain_scan_ctrl;

  logic       JTCK = 1'b0;
  logic       reset, JCE1, JCE2, JSHIFT, JUPDATE, tdo1_i, tdo2_i;
  logic       tdo_o, scan_ok, scan_err;
  logic [1:0] capture_en, shift_en, update_en, active_chain;
  logic [7:0] bit_count, err_count;

  typedef struct packed {
    logic [1:0] cap;
    logic [1:0] sh;
    logic [1:0] upd;
    logic       ok;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   fails     = 0;
  int   cyc_no    = 0;
  int   exp_err   = 0;

  jtag_chain_scan_ctrl #(.LEN1(4), .LEN2(4), .CNT_W(8)) dut (
    .JTCK(JTCK), .reset(reset), .JCE1(JCE1), .JCE2(JCE2), .JSHIFT(JSHIFT),
    .JUPDATE(JUPDATE), .tdo1_i(tdo1_i), .tdo2_i(tdo2_i), .tdo_o(tdo_o),
    .capture_en(capture_en), .shift_en(shift_en), .update_en(update_en),
    .active_chain(active_chain), .bit_count(bit_count), .scan_ok(scan_ok),
    .scan_err(scan_err), .err_count(err_count)
  );

  always #5 JTCK = ~JTCK;

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic cyc(input logic rst, input logic j1, input logic j2, input logic sh,
                     input logic up, input logic [1:0] ecap, input logic [1:0] esh,
                     input logic [1:0] eupd, input logic eok, input logic eerr);
    @(posedge JTCK); #1;
    reset   = rst;
    JCE1    = j1;
    JCE2    = j2;
    JSHIFT  = sh;
    JUPDATE = up;
    exp_q.push_back({ecap, esh, eupd, eok, eerr});
  endtask

  always @(negedge JTCK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if ({capture_en, shift_en, update_en, scan_ok, scan_err} !== e) begin
        fails++;
        $display("FAIL scoreboard cycle %0d: cap/shift/upd/ok/err got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b",
                 cyc_no, capture_en, shift_en, update_en, scan_ok, scan_err,
                 e.cap, e.sh, e.upd, e.ok, e.err);
      end
    end
    cyc_no++;
  end

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic test_reset();
    tdo1_i = 1'b1;
    tdo2_i = 1'b1;
    // JCE1 during reset must not start a capture.
    cyc(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    @(negedge JTCK); #1;
    tests_run++;
    if (bit_count !== 8'd0 || err_count !== 8'd0 || active_chain !== 2'b00 || tdo_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d err=%0d act=%b tdo=%b want 0/0/00/0",
               bit_count, err_count, active_chain, tdo_o);
    end
  endtask

  task automatic test_chain2_ok();
    cyc(0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    @(negedge JTCK); #1;
    tests_run++;
    if (active_chain !== 2'b10 || bit_count !== 8'd1) begin
      fails++;
      $display("FAIL chain2_mid: act=%b cnt=%0d want 10/1", active_chain, bit_count);
    end
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    @(negedge JTCK); #1;
    tests_run++;
    if (bit_count !== 8'd4 || err_count !== 8'd0 || active_chain !== 2'b00) begin
      fails++;
      $display("FAIL chain2_end: cnt=%0d err=%0d act=%b want 4/0/00",
               bit_count, err_count, active_chain);
    end
  endtask

  task automatic test_tdo_mux();
    tdo1_i = 1'b1;
    tdo2_i = 1'b0;
    cyc(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc(0, 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    @(negedge JTCK); #1;
    tests_run++;
    if (tdo_o !== 1'b1) begin
      fails++;
      $display("FAIL tdo_chain1_hi: tdo_o=%b want 1", tdo_o);
    end
    tdo1_i = 1'b0;
    tdo2_i = 1'b1;
    #1;
    tests_run++;
    if (tdo_o !== 1'b0) begin
      fails++;
      $display("FAIL tdo_chain1_lo: tdo_o=%b want 0", tdo_o);
    end
    // One-bit scan is rejected on update.
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
    bump_err();
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    tdo1_i = 1'b1;
    tdo2_i = 1'b1;
    @(negedge JTCK); #1;
    tests_run++;
    if (tdo_o !== 1'b0 || active_chain !== 2'b00 || err_count !== 8'(exp_err)) begin
      fails++;
      $display("FAIL tdo_idle: tdo=%b act=%b err=%0d want 0/00/%0d",
               tdo_o, active_chain, err_count, exp_err);
    end
  endtask

  task automatic test_conflict();
    cyc(0, 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    bump_err();
    // JCE2 stays high throughout and must be ignored.
    cyc(0, 1, 1, 1, 0, 2'b00, 2'b01, 2'b00, 0, 1);
    @(negedge JTCK); #1;
    tests_run++;
    if (active_chain !== 2'b01 || err_count !== 8'(exp_err)) begin
      fails++;
      $display("FAIL conflict: act=%b err=%0d want 01/%0d", active_chain, err_count, exp_err);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    cyc(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    @(negedge JTCK); #1;
    tests_run++;
    if (bit_count !== 8'd4 || err_count !== 8'(exp_err)) begin
      fails++;
      $display("FAIL conflict_end: cnt=%0d err=%0d want 4/%0d", bit_count, err_count, exp_err);
    end
  endtask

  task automatic test_pause();
    cyc(0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0, 0);
    @(negedge JTCK); #1;
    tests_run++;
    if (bit_count !== 8'd4 || active_chain !== 2'b10) begin
      fails++;
      $display("FAIL pause: cnt=%0d act=%b want 4/10", bit_count, active_chain);
    end
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
  endtask

  task automatic test_len_mismatch();
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
      cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      cyc(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
      bump_err();
      cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
      if (i == 0) begin
        @(negedge JTCK); #1;
        tests_run++;
        if (err_count !== 8'(exp_err) || bit_count !== 8'd3) begin
          fails++;
          $display("FAIL len_mismatch_first: err=%0d cnt=%0d want %0d/3",
                   err_count, bit_count, exp_err);
        end
      end
    end
    @(negedge JTCK); #1;
    tests_run++;
    if (err_count !== 8'd255) begin
      fails++;
      $display("FAIL err_saturate: err=%0d want 255", err_count);
    end
  endtask

  task automatic test_reset_mid_scan();
    cyc(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    cyc(0, 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    cyc(0, 1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    cyc(1, 1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    exp_err = 0;
    @(negedge JTCK); #1;
    tests_run++;
    if (bit_count !== 8'd0 || err_count !== 8'd0 || active_chain !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_scan: cnt=%0d err=%0d act=%b want 0/0/00",
               bit_count, err_count, active_chain);
    end
  endtask

  initial begin
    reset   = 1'b1;
    JCE1    = 1'b0;
    JCE2    = 1'b0;
    JSHIFT  = 1'b0;
    JUPDATE = 1'b0;
    tdo1_i  = 1'b0;
    tdo2_i  = 1'b0;
    repeat (2) @(posedge JTCK);
    test_reset();
    test_chain2_ok();
    test_tdo_mux();
    test_conflict();
    test_pause();
    test_len_mismatch();
    test_reset_mid_scan();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
